// File: rtl/mv_row_sequencer.sv
// mv_row_sequencer: feeds one matrix-vector MAC node column row by row and returns each row result over valid/ready.
module mv_row_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int ROW_W   = 6,
  parameter int MAC_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       len,
  input  logic [ROW_W-1:0]        rows,
  input  logic                    sub_mode,
  input  logic                    cascade,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       vec_addr,
  input  logic [24:0]             vec_rdata,
  output logic [ROW_W+ADDR_W-1:0] mat_addr,
  input  logic [17:0]             mat_rdata,
  output logic [24:0]             node_ain,
  output logic [17:0]             node_bin,
  output logic                    node_ce,
  output logic                    node_sclr,
  output logic                    node_subtract,
  output logic                    node_csel,
  input  logic [24:0]             node_res,
  output logic [24:0]             res_data,
  output logic [ROW_W-1:0]        res_row,
  output logic                    res_valid,
  input  logic                    res_ready
);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d, k_q, k_d;
  logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d, res_row_q, res_row_d;
  logic sub_q, sub_d, csel_q, csel_d, vld_q, vld_d, rd_en_q, rd_en_d, ce_q, ce_d;
  logic sclr_q, sclr_d, busy_q, busy_d, done_q, done_d, res_valid_q, res_valid_d;
  logic [24:0] ain_q, ain_d, res_data_q, res_data_d;
  logic [17:0] bin_q, bin_d;
  logic go, last_k, last_drain, hs;
  always_comb begin
    go = start && len != '0 && rows != '0;
    last_k = k_q == len_q - ADDR_W'(1);
    last_drain = k_q == ADDR_W'(MAC_LAT + 2);
    hs = res_valid_q && res_ready;
    state_d = state_q;
    len_d = len_q;
    rows_d = rows_q;
    row_d = row_q;
    k_d = k_q;
    sub_d = sub_q;
    csel_d = csel_q;
    done_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    res_row_d = res_row_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = CLEAR;
        len_d = len;
        rows_d = rows;
        sub_d = sub_mode;
        csel_d = cascade;
        row_d = '0;
      end
      CLEAR: begin
        state_d = STREAM;
        k_d = '0;
      end
      STREAM: begin
        k_d = last_k ? '0 : k_q + ADDR_W'(1);
        state_d = last_k ? DRAIN : STREAM;
      end
      DRAIN: begin
        k_d = last_drain ? '0 : k_q + ADDR_W'(1);
        state_d = last_drain ? HOLD : DRAIN;
        if (last_drain) begin
          res_data_d = node_res;
          res_row_d = row_q;
          res_valid_d = 1'b1;
        end
      end
      HOLD: if (hs) begin
        res_valid_d = 1'b0;
        if (row_q + ROW_W'(1) != rows_q) begin
          row_d = row_q + ROW_W'(1);
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
          done_d = 1'b1;
          row_d = '0;
          len_d = '0;
          rows_d = '0;
          sub_d = 1'b0;
          csel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_en_d = state_d == STREAM;
    ce_d = state_d inside {CLEAR, STREAM, DRAIN};
    sclr_d = state_d == CLEAR;
    busy_d = state_d != IDLE;
    vld_d = rd_en_q;
    ain_d = vld_q ? vec_rdata : '0;
    bin_d = vld_q ? mat_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      rows_q <= '0;
      row_q <= '0;
      k_q <= '0;
      sub_q <= 1'b0;
      csel_q <= 1'b0;
      vld_q <= 1'b0;
      rd_en_q <= 1'b0;
      ce_q <= 1'b0;
      sclr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_row_q <= '0;
      ain_q <= '0;
      bin_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      rows_q <= rows_d;
      row_q <= row_d;
      k_q <= k_d;
      sub_q <= sub_d;
      csel_q <= csel_d;
      vld_q <= vld_d;
      rd_en_q <= rd_en_d;
      ce_q <= ce_d;
      sclr_q <= sclr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_row_q <= res_row_d;
      ain_q <= ain_d;
      bin_q <= bin_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign rd_en = rd_en_q;
  assign vec_addr = k_q;
  assign mat_addr = {row_q, k_q};
  assign node_ain = ain_q;
  assign node_bin = bin_q;
  assign node_ce = ce_q;
  assign node_sclr = sclr_q;
  assign node_subtract = sub_q;
  assign node_csel = csel_q;
  assign res_data = res_data_q;
  assign res_row = res_row_q;
  assign res_valid = res_valid_q;
endmodule
